spi_device_shift: RTL
=====================

Name: spi_device_shift

Overview:
- SPI target-side character shifter: the far end of the existing host shifter, for an SPI device/loopback port.
- Oversamples the external sclk/csn/sdi pins in the clk_i domain.
- Assembles received characters into a parallel word.
- Serialises a buffered transmit word onto sdo.
- Uses the same length/lsb/edge-select programming model as the host shifter, so host and device can be cross-connected.

Parameters:
- MAX_CHAR, 32, maximum character length in bits; width of tx buffer, shift registers and p_out.
- CHAR_LEN_BITS, 5, width of len; log2(MAX_CHAR).

Ports:
- clk_i  in  1  system clock; must be at least 4x the sclk frequency.
- rst  in  1  reset, synchronous, active-high.
- csn_i  in  1  chip select from the pin, active low, asynchronous.
- sclk_i  in  1  serial clock from the pin, asynchronous.
- sdi_i  in  1  serial data in from the pin (host MOSI), asynchronous.
- sdo_o  out  1  serial data out to the pin (host MISO).
- sdo_oe_o  out  1  output enable for sdo; 1 while the synchronised csn is low.
- len  in  CHAR_LEN_BITS  character length in bits; 0 means MAX_CHAR.
- lsb  in  1  1 = LSB first on the line.
- rx_negedge  in  1  1 = sdi sampled on sclk falling edge.
- tx_negedge  in  1  1 = sdo updated on sclk falling edge.
- latch  in  1  write strobe for the tx buffer.
- byte_sel  in  4  byte enables for latch.
- p_in  in  32  parallel tx data.
- p_out  out  MAX_CHAR  last complete received character.
- rx_valid_o  out  1  one-cycle pulse when p_out updates.
- tx_full_o  out  1  tx buffer holds a word not yet consumed.
- busy_o  out  1  character in progress.
- underrun_o  out  1  sticky; a character started with the tx buffer empty.
- abort_o  out  1  one-cycle pulse when csn rises mid-character.
- clr_err  in  1  clears underrun_o.

Behaviour:
- Synchronisation
  - csn, sclk and sdi each pass through a 2-flop synchroniser plus one history flop.
  - Edge detect compares stage 2 with stage 3; data is sampled from the sdi stage aligned with sclk.
  - Pin-to-action latency is 3 clk_i cycles.
- Reset values: all outputs 0 (p_out 0, sdo_o 0, sdo_oe_o 0, tx_full_o 0); FSM in IDLE; tx buffer 0. Reset mid-character discards everything.
- Effective length: L = len, or MAX_CHAR when len == 0. The bit counter is CHAR_LEN_BITS+1 wide.
- Sample edge = rx_negedge ? sclk fall : sclk rise. Drive edge = tx_negedge ? sclk fall : sclk rise.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: when synchronised csn is low, go to LOAD.
  - LOAD (1 cycle):
    - copy tx buffer into tx shift register, clear tx_full_o;
    - if the buffer was empty, shift all zeros and set underrun_o;
    - cnt = L, clear the per-character "sampled" flag;
    - present the first bit on sdo: bit 0 if lsb, else bit L-1;
    - go to SHIFT.
  - SHIFT:
    - On each sample edge: store sdi at bit position L-cnt if lsb, else cnt-1; decrement cnt; set "sampled".
    - On a drive edge: advance sdo to the next bit only if "sampled" is set. The first drive edge therefore never skips bit 0, which covers all four CPOL/CPHA modes.
    - When cnt reaches 0 after a sample edge: p_out takes the assembled word and rx_valid_o pulses in the following cycle. Go to LOAD if csn is still low (back-to-back characters), else IDLE.
    - Bits above L-1 in p_out are 0.
  - Synchronised csn rising in SHIFT with cnt != 0: go to IDLE, discard the partial rx word, no rx_valid_o, pulse abort_o. The consumed tx word is not restored.
- busy_o = 1 in LOAD and SHIFT.
- tx buffer
  - latch writes the bytes selected by byte_sel and sets tx_full_o.
  - A latch while the buffer is full overwrites it.
  - latch in the same cycle as LOAD: LOAD takes the old contents; the new data is written and tx_full_o stays 1.
- underrun_o
  - Cleared by clr_err.
  - clr_err in the same cycle as a new underrun: set wins.
- sdo_o holds its value outside SHIFT/LOAD.

Decomposition:
- Shared package spi_device_pkg:
  - state encoding (IDLE/LOAD/SHIFT);
  - MAX_CHAR / CHAR_LEN_BITS defaults, matching the host SPI_MAX_CHAR / SPI_CHAR_LEN_BITS defines;
  - synchroniser depth constant (2).
- One sub-module, spi_pin_sync: per-signal 2-flop synchroniser with history flop and rise/fall pulse outputs. Instantiated for csn, sclk and sdi.
- FSM, counter, buffers and shifters stay in the top module.

Test Plan:
1. Mode 0 (rx_negedge=0, tx_negedge=1), len=8, lsb=0; tx buffer 0xA5; host shifts 0x3C at clk_i/8 -> sdo bits 1,0,1,0,0,1,0,1; p_out=0x0000003C; one rx_valid_o pulse; tx_full_o falls at LOAD.
2. Mode 1 (rx_negedge=1, tx_negedge=0), len=0 (32 bits), lsb=1; p_in=0xDEADBEEF, byte_sel=4'hF -> sdo LSB first reproduces 0xDEADBEEF; rx word 0x12345678 appears on p_out.
3. Back-to-back: csn held low for 2x8-bit characters, only one word latched -> first character sends the buffer, second sends 0x00, underrun_o=1, two rx_valid_o pulses. clr_err then clears underrun_o.
4. csn rises after 5 of 8 sample edges -> abort_o pulses, no rx_valid_o, p_out unchanged, FSM in IDLE; next full character is received correctly.
5. latch with byte_sel=4'b0010, p_in=0x0000AB00, in the same cycle as LOAD -> the old word is shifted out; buffer byte 1 = 0xAB; tx_full_o stays 1.
6. rst asserted mid-SHIFT -> next cycle all outputs 0, busy_o=0; after rst drops with csn low, a full character completes normally.

Source files
------------

// File: rtl/spi_device_pkg.sv
// Shared definitions for the SPI device-side shifter.
// Holds the FSM state encoding, the default character geometry (kept equal to
// the host shifter's SPI_MAX_CHAR / SPI_CHAR_LEN_BITS defaults) and the pin
// synchroniser depth.
package spi_device_pkg;

  localparam int unsigned DEF_MAX_CHAR      = 32;
  localparam int unsigned DEF_CHAR_LEN_BITS = 5;
  localparam int unsigned SYNC_DEPTH        = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_device_shift_sync.sv
// spi_pin_sync: brings one asynchronous SPI pin into the clk domain.
// A SYNC_DEPTH-flop synchroniser is followed by one history flop; the edge
// pulses compare the last synchroniser stage with the history flop.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   pin           asynchronous pin input
//   q             synchronised level (last synchroniser stage)
//   q_d           q delayed by one clk (history flop)
//   rise_c/fall_c single-cycle edge pulses (combinational from q/q_d)
module spi_pin_sync
  import spi_device_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic q,
  output logic q_d,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_DEPTH-1:0] sync;

  // Synchroniser chain plus history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_DEPTH{RST_VAL}};
      q_d  <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], pin};
      q_d  <= sync[SYNC_DEPTH-1];
    end
  end

  assign q      = sync[SYNC_DEPTH-1];
  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/spi_device_shift.sv
// spi_device_shift: SPI target-side character shifter.
// Oversamples csn/sclk/sdi in the clk_i domain, assembles received characters
// into p_out and serialises a buffered transmit word onto sdo_o, using the
// same len/lsb/rx_negedge/tx_negedge model as the host shifter.
// Ports:
//   clk_i, rst                 clock, synchronous active-high reset
//   csn_i, sclk_i, sdi_i       asynchronous SPI pins from the host
//   sdo_o, sdo_oe_o            serial data out and its output enable
//   len, lsb                   character length (0 = MAX_CHAR), bit order
//   rx_negedge, tx_negedge     sample / drive edge select
//   latch, byte_sel, p_in      byte-masked write into the tx buffer
//   p_out, rx_valid_o          last received character and its update pulse
//   tx_full_o, busy_o          tx buffer occupied, character in progress
//   underrun_o, clr_err        sticky empty-buffer flag and its clear
//   abort_o                    pulse when csn is released mid-character
module spi_device_shift
  import spi_device_pkg::*;
#(
  parameter int unsigned MAX_CHAR      = DEF_MAX_CHAR,
  parameter int unsigned CHAR_LEN_BITS = DEF_CHAR_LEN_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     csn_i,
  input  logic                     sclk_i,
  input  logic                     sdi_i,
  output logic                     sdo_o,
  output logic                     sdo_oe_o,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     rx_negedge,
  input  logic                     tx_negedge,
  input  logic                     latch,
  input  logic [3:0]               byte_sel,
  input  logic [31:0]              p_in,
  output logic [MAX_CHAR-1:0]      p_out,
  output logic                     rx_valid_o,
  output logic                     tx_full_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic                     abort_o,
  input  logic                     clr_err
);

  localparam int unsigned CNT_W = CHAR_LEN_BITS + 1;
  localparam int unsigned BUF_W = (MAX_CHAR > 32) ? MAX_CHAR : 32;

  // Synchronised pins
  logic csn_q, csn_d, csn_rise, csn_fall;
  logic sclk_q, sclk_d, sclk_rise, sclk_fall;
  logic sdi_q, sdi_d, sdi_rise, sdi_fall;
  logic unused_sync;

  spi_pin_sync #(.RST_VAL(1'b1)) u_csn_sync (
    .clk(clk_i), .rst(rst), .pin(csn_i),
    .q(csn_q), .q_d(csn_d), .rise_c(csn_rise), .fall_c(csn_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk_i), .rst(rst), .pin(sclk_i),
    .q(sclk_q), .q_d(sclk_d), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sdi_sync (
    .clk(clk_i), .rst(rst), .pin(sdi_i),
    .q(sdi_q), .q_d(sdi_d), .rise_c(sdi_rise), .fall_c(sdi_fall)
  );

  // csn is used as a level; sdi is sampled at the stage aligned with sclk.
  assign unused_sync = ^{csn_d, csn_rise, csn_fall, sclk_q, sclk_d,
                         sdi_d, sdi_rise, sdi_fall};

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     sampled;
  logic [MAX_CHAR-1:0]      tx_buf;
  logic [MAX_CHAR-1:0]      tx_sh;
  logic [MAX_CHAR-1:0]      rx_sh;
  logic [CHAR_LEN_BITS-1:0] tx_idx;

  logic                     sample_edge;
  logic                     drive_edge;
  logic [CNT_W-1:0]         eff_len;
  logic [CHAR_LEN_BITS-1:0] rx_pos;
  logic [CHAR_LEN_BITS-1:0] tx_first;
  logic [CHAR_LEN_BITS-1:0] tx_idx_next;
  logic [MAX_CHAR-1:0]      rx_next;
  logic [BUF_W-1:0]         merged;

  assign sample_edge = rx_negedge ? sclk_fall : sclk_rise;
  assign drive_edge  = tx_negedge ? sclk_fall : sclk_rise;
  assign eff_len     = (len == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(len);

  // Receive bit position counts up from 0 (lsb) or down from L-1 (msb).
  assign rx_pos = lsb ? CHAR_LEN_BITS'(eff_len - cnt)
                      : CHAR_LEN_BITS'(cnt - CNT_W'(1));

  assign tx_first    = lsb ? '0 : CHAR_LEN_BITS'(eff_len - CNT_W'(1));
  assign tx_idx_next = lsb ? tx_idx + CHAR_LEN_BITS'(1)
                           : tx_idx - CHAR_LEN_BITS'(1);

  // Receive word including the bit captured on this sample edge.
  always_comb begin
    rx_next         = rx_sh;
    rx_next[rx_pos] = sdi_q;
  end

  // Byte-masked merge of p_in into the tx buffer.
  always_comb begin
    merged = BUF_W'(tx_buf);
    for (int b = 0; b < 4; b++) begin
      if (byte_sel[b]) merged[b*8 +: 8] = p_in[b*8 +: 8];
    end
  end

  // Character FSM, shifters, tx buffer and status flags.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sampled    <= 1'b0;
      tx_buf     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      tx_idx     <= '0;
      sdo_o      <= 1'b0;
      sdo_oe_o   <= 1'b0;
      p_out      <= '0;
      rx_valid_o <= 1'b0;
      tx_full_o  <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      abort_o    <= 1'b0;
      sdo_oe_o   <= ~csn_q;
      if (clr_err) underrun_o <= 1'b0;

      case (state)
        IDLE: begin
          if (!csn_q) begin
            state  <= LOAD;
            busy_o <= 1'b1;
          end
        end

        LOAD: begin
          // An empty buffer shifts zeros; the underrun set overrides clr_err.
          tx_sh     <= tx_full_o ? tx_buf : '0;
          sdo_o     <= tx_full_o ? tx_buf[tx_first] : 1'b0;
          if (!tx_full_o) underrun_o <= 1'b1;
          tx_full_o <= 1'b0;
          tx_idx    <= tx_first;
          cnt       <= eff_len;
          sampled   <= 1'b0;
          rx_sh     <= '0;
          state     <= SHIFT;
        end

        SHIFT: begin
          if (sample_edge && cnt == CNT_W'(1)) begin
            // Last bit: publish the word; stay busy if csn is still low.
            rx_sh      <= rx_next;
            cnt        <= '0;
            sampled    <= 1'b1;
            p_out      <= rx_next;
            rx_valid_o <= 1'b1;
            if (csn_q) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state  <= LOAD;
            end
          end else if (csn_q) begin
            // csn released mid-character (including right after a reload).
            state   <= IDLE;
            busy_o  <= 1'b0;
            abort_o <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_sh   <= rx_next;
              cnt     <= cnt - CNT_W'(1);
              sampled <= 1'b1;
            end
            // Holding the first bit until a sample has happened lets the
            // leading drive edge of CPHA=1 modes leave bit 0 on the line.
            if (drive_edge && sampled) begin
              tx_idx <= tx_idx_next;
              sdo_o  <= tx_sh[tx_idx_next];
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase

      // A write in the LOAD cycle lands after LOAD copied the old word.
      if (latch) begin
        tx_buf    <= MAX_CHAR'(merged);
        tx_full_o <= 1'b1;
      end
    end
  end

endmodule
